// File: rtl/counter_bist_pkg.sv
// counter_bist_pkg: shared state encoding and default MISR constants for the counter BIST compactor.
package counter_bist_pkg;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] DEF_POLY = 8'hB8;
    localparam logic [7:0] DEF_SEED = 8'h00;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/bist_misr_step.sv
// bist_misr_step: one Galois MISR fold, combinational.
module bist_misr_step
    import counter_bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY)
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig_next
);
    assign sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
endmodule

// File: rtl/counter_bist_response_compactor.sv
// counter_bist_response_compactor: folds a window of DUT output samples into a MISR
// signature and reports a registered golden compare through a start/done handshake.
module counter_bist_response_compactor
    import counter_bist_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               WINDOW = 16,
    parameter int               SKIP   = 1,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             din,
    input  logic [WIDTH-1:0]             golden,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [WIDTH-1:0]             signature,
    output logic [$clog2(WINDOW+1)-1:0]  sample_cnt
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int SW = cnt_w(SKIP);
    localparam state_t FIRST = (SKIP > 0) ? S_SKIP : S_CAPTURE;

    state_t          state, state_next;
    logic [SW-1:0]   skip_cnt;
    logic [WIDTH-1:0] sig_next;
    logic            start_ok, last_skip, last_sample;

    assign start_ok    = start && (state == S_IDLE || state == S_DONE);
    assign last_skip   = skip_cnt == SW'(SKIP - 1);
    assign last_sample = sample_cnt == CW'(WINDOW - 1);

    bist_misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .sig      (signature),
        .din      (din),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = start_ok                                ? FIRST     :
                     (state == S_SKIP    && last_skip)       ? S_CAPTURE :
                     (state == S_CAPTURE && last_sample)     ? S_DONE    : state;
    end

    always_comb begin
        busy = (state == S_SKIP) || (state == S_CAPTURE);
        done = state == S_DONE;
    end

    // pass is only ever set on the DONE-entry edge and cleared on restart
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signature  <= SEED;
            sample_cnt <= '0;
            skip_cnt   <= '0;
            pass       <= 1'b0;
        end else if (start_ok) begin
            signature  <= SEED;
            sample_cnt <= '0;
            skip_cnt   <= '0;
            pass       <= 1'b0;
        end else if (state == S_SKIP) begin
            skip_cnt <= skip_cnt + 1'b1;
        end else if (state == S_CAPTURE) begin
            signature  <= sig_next;
            sample_cnt <= sample_cnt + 1'b1;
            if (last_sample) pass <= sig_next == golden;
        end
    end
endmodule

// File: tb/tb_counter_bist_response_compactor.sv
// tb_counter_bist_response_compactor: scoreboard bench for the BIST response compactor
// across default, single-sample and two-sample window configurations.
module tb_counter_bist_response_compactor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start0, start1, start2;
    logic [7:0] din, golden, model_sig, model_din, model_next;
    logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] sig0, sig1, sig2;
    logic [4:0] cnt0;
    logic [0:0] cnt1;
    logic [1:0] cnt2;
    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    counter_bist_response_compactor u0 (
        .clk(clk), .reset(reset), .start(start0), .din(din), .golden(golden),
        .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .sample_cnt(cnt0));

    counter_bist_response_compactor #(.WINDOW(1), .SKIP(0)) u1 (
        .clk(clk), .reset(reset), .start(start1), .din(din), .golden(golden),
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .sample_cnt(cnt1));

    counter_bist_response_compactor #(.WINDOW(2), .SKIP(0)) u2 (
        .clk(clk), .reset(reset), .start(start2), .din(din), .golden(golden),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .sample_cnt(cnt2));

    bist_misr_step #(.WIDTH(8), .POLY(8'hB8)) u_model (
        .sig(model_sig), .din(model_din), .sig_next(model_next));

    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'hB8 : 8'h00) ^ d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if ({busy0, done0, pass0, sig0, cnt0} !== 16'h0) begin
            fails++;
            $display("FAIL reset_u0: got %h expected %h", {busy0, done0, pass0, sig0, cnt0}, 16'h0);
        end
        tests++;
        if ({busy1, done1, pass1, sig1, cnt1, busy2, done2, pass2, sig2, cnt2} !== 25'h0) begin
            fails++;
            $display("FAIL reset_u1_u2: got %h expected 0",
                     {busy1, done1, pass1, sig1, cnt1, busy2, done2, pass2, sig2, cnt2});
        end
        tick;
        tick;
        reset = 1'b1;
        tick;
        tests++;
        if ({busy0, done0} !== 2'b00) begin
            fails++;
            $display("FAIL idle_no_start: got %b expected 00", {busy0, done0});
        end
    endtask

    task automatic test_window1;
        logic [7:0] e;
        start1 = 1'b1; din = 8'h5A; golden = 8'h5A;
        tick;
        start1 = 1'b0;
        exp_q.push_back(8'h5A);
        tick;
        e = exp_q.pop_front();
        tests++;
        if (sig1 !== e) begin fails++; $display("FAIL w1_sig: got %h expected %h", sig1, e); end
        tests++;
        if ({done1, pass1, busy1, cnt1} !== 4'b1101) begin
            fails++; $display("FAIL w1_pass: got %b expected 1101", {done1, pass1, busy1, cnt1});
        end
        golden = 8'h5B; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tests++;
        if ({done1, pass1, busy1} !== 3'b001) begin
            fails++; $display("FAIL w1_restart: got %b expected 001", {done1, pass1, busy1});
        end
        exp_q.push_back(8'h5A);
        tick;
        e = exp_q.pop_front();
        tests++;
        if ({done1, pass1, sig1} !== {2'b10, e}) begin
            fails++; $display("FAIL w1_fail_golden: got %h expected %h", {done1, pass1, sig1}, {2'b10, e});
        end
    endtask

    task automatic test_window2;
        logic [7:0] e;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        din = 8'h80; exp_q.push_back(8'h80);
        tick;
        e = exp_q.pop_front();
        tests++;
        if ({busy2, done2, sig2} !== {2'b10, e}) begin
            fails++; $display("FAIL w2_first: got %h expected %h", {busy2, done2, sig2}, {2'b10, e});
        end
        din = 8'h00; exp_q.push_back(8'hB8);
        tick;
        e = exp_q.pop_front();
        tests++;
        if ({busy2, done2, sig2, cnt2} !== {2'b01, e, 2'd2}) begin
            fails++; $display("FAIL w2_second: got %h expected %h", {busy2, done2, sig2, cnt2}, {2'b01, e, 2'd2});
        end
    endtask

    task automatic test_zero_din;
        logic [7:0] exp_sig, e, hold;
        din = 8'h00; golden = 8'h00; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        exp_sig = 8'h00;
        tests++;
        if (busy0 !== 1'b1) begin fails++; $display("FAIL zero_busy_accept: got %b expected 1", busy0); end
        for (int k = 1; k <= 17; k++) begin
            if (k >= 2) begin
                exp_sig = ref_step(exp_sig, din);
                exp_q.push_back(exp_sig);
            end
            tick;
            if (k >= 2) begin
                e = exp_q.pop_front();
                tests++;
                if (sig0 !== e) begin fails++; $display("FAIL zero_sig%0d: got %h expected %h", k, sig0, e); end
            end
            tests++;
            if ({busy0, done0} !== ((k == 17) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL zero_state%0d: got %b expected %b", k, {busy0, done0}, (k == 17) ? 2'b01 : 2'b10);
            end
        end
        tests++;
        if ({pass0, cnt0} !== {1'b1, 5'd16}) begin
            fails++; $display("FAIL zero_done: got %h expected %h", {pass0, cnt0}, {1'b1, 5'd16});
        end
        hold = sig0;
        din = 8'hFF;
        tick;
        tick;
        tests++;
        if ({done0, pass0, sig0, cnt0} !== {2'b11, hold, 5'd16}) begin
            fails++; $display("FAIL zero_hold: got %h expected %h", {done0, pass0, sig0, cnt0}, {2'b11, hold, 5'd16});
        end
    endtask

    task automatic test_async_reset;
        din = 8'h3C; golden = 8'h00; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (8) tick;
        tests++;
        if ({busy0, cnt0} !== {1'b1, 5'd7}) begin
            fails++; $display("FAIL arst_mid: got %h expected %h", {busy0, cnt0}, {1'b1, 5'd7});
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({busy0, done0, pass0, sig0, cnt0} !== 16'h0) begin
            fails++; $display("FAIL arst_clear: got %h expected 0", {busy0, done0, pass0, sig0, cnt0});
        end
        #2 reset = 1'b1;
        din = 8'h00;
        tick;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (16) tick;
        tests++;
        if (done0 !== 1'b0) begin fails++; $display("FAIL arst_early: got %b expected 0", done0); end
        tick;
        tests++;
        if ({done0, pass0, cnt0} !== {2'b11, 5'd16}) begin
            fails++; $display("FAIL arst_rerun: got %h expected %h", {done0, pass0, cnt0}, {2'b11, 5'd16});
        end
    endtask

    task automatic test_start_handling;
        int low;
        din = 8'h00; golden = 8'h00; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (5) tick;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (10) tick;
        tests++;
        if ({done0, cnt0} !== {1'b0, 5'd15}) begin
            fails++; $display("FAIL ignore_start_early: got %h expected %h", {done0, cnt0}, {1'b0, 5'd15});
        end
        tick;
        tests++;
        if ({done0, cnt0} !== {1'b1, 5'd16}) begin
            fails++; $display("FAIL ignore_start_done: got %h expected %h", {done0, cnt0}, {1'b1, 5'd16});
        end
        start0 = 1'b1;
        low = 0;
        for (int n = 0; n < 40; n++) begin
            tick;
            if (done0 === 1'b1) break;
            low++;
        end
        tests++;
        if (low != 17) begin fails++; $display("FAIL free_run_low: got %0d expected 17", low); end
        start0 = 1'b0;
        tick;
        tests++;
        if ({done0, pass0} !== 2'b11) begin
            fails++; $display("FAIL free_run_hold: got %b expected 11", {done0, pass0});
        end
    endtask

    task automatic test_counter_bench;
        logic [7:0] stream[16];
        logic [7:0] bc, exp_sig, e;
        bc = 8'($urandom);
        foreach (stream[i]) begin
            bc = ($urandom_range(0, 5) == 0) ? 8'h00 : bc + 8'h01;
            stream[i] = bc;
        end
        model_sig = 8'h00;
        foreach (stream[i]) begin
            model_din = stream[i];
            #1;
            model_sig = model_next;
        end
        golden = model_sig;
        for (int r = 0; r < 2; r++) begin
            start0 = 1'b1;
            tick;
            start0 = 1'b0;
            exp_sig = 8'h00;
            tick;
            for (int i = 0; i < 16; i++) begin
                din = stream[i] ^ ((r == 1 && i == 8) ? 8'h08 : 8'h00);
                exp_sig = ref_step(exp_sig, din);
                exp_q.push_back(exp_sig);
                tick;
                e = exp_q.pop_front();
                tests++;
                if (sig0 !== e) begin fails++; $display("FAIL bench_sig r%0d s%0d: got %h expected %h", r, i, sig0, e); end
            end
            tests++;
            if ({done0, pass0} !== {1'b1, r == 0}) begin
                fails++; $display("FAIL bench_pass r%0d: got %b expected %b", r, {done0, pass0}, {1'b1, r == 0});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        din = 8'h00; golden = 8'h00; model_sig = 8'h00; model_din = 8'h00;
        test_reset;
        test_window1;
        test_window2;
        test_zero_din;
        test_async_reset;
        test_start_handling;
        test_counter_bench;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
